td4x_core: RTL and testbench

// Parametrised successor to the TD4 CPU + program-memory pair. Holds a
// 2^ADDR_W-entry program memory and a TD4-ISA core with DATA_W-bit A/B/OUT regs.

---
 rtl/td4x_core.sv | 180 ++++++++++++++++++
 tb/tb_td4x_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/td4x_core.sv
// td4x_core: TD4-ISA core with an on-chip program memory, single-step mode,
// a hardware breakpoint and a synchronous soft restart.
module td4x_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              restart,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wr,
    input  logic [3:0]        ld_op,
    input  logic [DATA_W-1:0] ld_imm,
    input  logic [DATA_W-1:0] in_port,
    output logic [3:0]        mem_op,
    output logic [DATA_W-1:0] mem_imm,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] out_port,
    output logic              carry,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_READ = 2'b01;
    localparam logic [1:0] M_RUN  = 2'b10;
    localparam logic [1:0] M_STEP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_BREAK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q  [DEPTH];
    logic [3:0]        op_d  [DEPTH];
    logic [DATA_W-1:0] imm_q [DEPTH];
    logic [DATA_W-1:0] imm_d [DEPTH];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              step_q, step_d;
    logic              bp_armed_q, bp_armed_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        cur_op;
    logic [DATA_W-1:0] cur_imm;
    logic [DATA_W:0]   sum_a, sum_b;
    logic [ADDR_W-1:0] pc_inc, jmp_tgt;
    logic              bp_hit, step_edge, exec;

    // Memory port shown to the outside follows the loader address when idle, else PC
    always_comb begin
        rd_addr = (mode == M_LOAD || mode == M_READ) ? ld_addr : pc_q;
        mem_op  = op_q[rd_addr];
        mem_imm = imm_q[rd_addr];
        cur_op  = op_q[pc_q];
        cur_imm = imm_q[pc_q];
    end

    // Program memory write port, active only in LOAD mode
    always_comb begin
        op_d  = op_q;
        imm_d = imm_q;
        if (mode == M_LOAD && ld_wr) begin
            op_d[ld_addr]  = ld_op;
            imm_d[ld_addr] = ld_imm;
        end
    end

    // Mode FSM: breakpoint is checked before execution so the bp instruction waits
    always_comb begin
        bp_hit    = bp_en && bp_armed_q && (pc_q == bp_addr);
        step_edge = step_req && !step_q;
        state_d   = S_IDLE;
        exec      = 1'b0;
        case (mode)
            M_RUN: begin
                if (state_q == S_BREAK || bp_hit) begin
                    state_d = S_BREAK;
                end else begin
                    state_d = S_RUN;
                    exec    = 1'b1;
                end
            end
            M_STEP: begin
                state_d = S_STEP;
                exec    = step_edge;
            end
            default: state_d = S_IDLE;
        endcase
        if (restart) state_d = S_IDLE;
    end

    // Datapath: restart beats execute; idle cycles hold everything
    always_comb begin
        sum_a      = {1'b0, a_q} + {1'b0, cur_imm};
        sum_b      = {1'b0, b_q} + {1'b0, cur_imm};
        pc_inc     = pc_q + ADDR_W'(1);
        jmp_tgt    = cur_imm[ADDR_W-1:0];
        step_d     = step_req;
        a_d        = a_q;
        b_d        = b_q;
        out_d      = out_q;
        carry_d    = carry_q;
        pc_d       = pc_q;
        bp_armed_d = bp_armed_q;
        if (restart) begin
            a_d        = '0;
            b_d        = '0;
            out_d      = '0;
            carry_d    = 1'b0;
            pc_d       = '0;
            bp_armed_d = 1'b1;
        end else begin
            if (exec) begin
                carry_d = 1'b0;
                pc_d    = pc_inc;
                case (cur_op)
                    4'b0000: begin a_d = sum_a[DATA_W-1:0]; carry_d = sum_a[DATA_W]; end
                    4'b0001: a_d = b_q;
                    4'b0010: a_d = in_port;
                    4'b0011: a_d = cur_imm;
                    4'b0100: b_d = a_q;
                    4'b0101: begin b_d = sum_b[DATA_W-1:0]; carry_d = sum_b[DATA_W]; end
                    4'b0110: b_d = in_port;
                    4'b0111: b_d = cur_imm;
                    4'b1001: out_d = b_q;
                    4'b1011: out_d = cur_imm;
                    4'b1110: if (!carry_q) pc_d = jmp_tgt;
                    4'b1111: pc_d = jmp_tgt;
                    default: ;
                endcase
            end
            // Disarm on the halt itself, re-arm once PC moves off the break address
            if (state_d == S_BREAK && state_q != S_BREAK) bp_armed_d = 1'b0;
            else if (pc_d != pc_q)                        bp_armed_d = 1'b1;
        end
    end

    // State registers, memory included, all cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            carry_q    <= 1'b0;
            pc_q       <= '0;
            step_q     <= 1'b0;
            bp_armed_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            pc_q       <= pc_d;
            step_q     <= step_d;
            bp_armed_q <= bp_armed_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
        end
    end

    assign reg_a    = a_q;
    assign reg_b    = b_q;
    assign out_port = out_q;
    assign carry    = carry_q;
    assign pc       = pc_q;
    assign halted   = (state_q == S_BREAK);

endmodule

// File: tb/tb_td4x_core.sv
// Directed bench for td4x_core: load/read, run, counter wrap, breakpoint/step,
// restart, ISA spot checks and asynchronous reset.
module tb_td4x_core;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       restart, step_req, bp_en, ld_wr;
    logic [3:0] bp_addr, ld_addr, ld_op, ld_imm, in_port;
    logic [3:0] mem_op, mem_imm, reg_a, reg_b, out_port, pc;
    logic       carry, halted;

    int npass = 0;
    int ntotal = 0;

    td4x_core #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .restart(restart),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .ld_addr(ld_addr), .ld_wr(ld_wr), .ld_op(ld_op), .ld_imm(ld_imm),
        .in_port(in_port), .mem_op(mem_op), .mem_imm(mem_imm),
        .reg_a(reg_a), .reg_b(reg_b), .out_port(out_port), .carry(carry),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] op, input logic [3:0] im);
        mode = 2'b00; ld_addr = a; ld_op = op; ld_imm = im; ld_wr = 1'b1;
        tick();
        ld_wr = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b01; restart = 1'b0; step_req = 1'b0; bp_en = 1'b0;
        bp_addr = '0; ld_addr = '0; ld_wr = 1'b0; ld_op = '0; ld_imm = '0; in_port = '0;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_a", reg_a, 0);
        chk("rst_out", out_port, 0);
        chk("rst_halt", halted, 0);
        chk("rst_mem", {mem_op, mem_imm}, 0);
        rst_n = 1'b1;
        tick();

        // load / read
        load(4'd0, 4'b0011, 4'h5);
        load(4'd1, 4'b0000, 4'hC);
        mode = 2'b01; ld_addr = 4'd1; #1;
        chk("read1", {mem_op, mem_imm}, 8'h0C);
        ld_addr = 4'd0; #1;
        chk("read0", {mem_op, mem_imm}, 8'h35);

        // run: MOV A,5 ; ADD A,C ; NOP
        mode = 2'b10;
        tick(2);
        chk("run_a", reg_a, 1);
        chk("run_c", carry, 1);
        chk("run_pc", pc, 2);
        tick();
        chk("nop_c", carry, 0);
        chk("nop_pc", pc, 3);
        mode = 2'b01;
        tick(3);
        chk("frz_pc", pc, 3);
        chk("frz_a", reg_a, 1);

        // restart mid-run keeps memory
        mode = 2'b10;
        tick();
        chk("resume_pc", pc, 4);
        do_restart();
        chk("rs_pc", pc, 0);
        chk("rs_a", reg_a, 0);
        mode = 2'b01; ld_addr = 4'd1; #1;
        chk("rs_mem", {mem_op, mem_imm}, 8'h0C);

        // counter: ADD A,1 ; JMP 0
        load(4'd0, 4'b0000, 4'h1);
        load(4'd1, 4'b1111, 4'h0);
        do_restart();
        mode = 2'b10;
        tick();
        chk("cnt1_a", reg_a, 1);
        chk("cnt1_pc", pc, 1);
        tick();
        chk("cnt1_jpc", pc, 0);
        tick(29);
        chk("cntw_a", reg_a, 0);
        chk("cntw_c", carry, 1);
        chk("cntw_pc", pc, 1);
        tick();
        chk("cntj_c", carry, 0);
        chk("cntj_pc", pc, 0);

        // breakpoint at 3 on a linear ADD A,1 program
        for (int i = 0; i < 16; i++) load(4'(i), 4'b0000, 4'h1);
        do_restart();
        bp_en = 1'b1; bp_addr = 4'd3;
        mode = 2'b10;
        tick(3);
        chk("bp_pre_pc", pc, 3);
        chk("bp_pre_h", halted, 0);
        tick();
        chk("bp_h", halted, 1);
        chk("bp_pc", pc, 3);
        chk("bp_a", reg_a, 3);
        tick();
        chk("bp_hold", halted, 1);
        chk("bp_hold_a", reg_a, 3);
        mode = 2'b11;
        tick();
        chk("st_h", halted, 0);
        chk("st_pc0", pc, 3);
        step_req = 1'b1;
        tick(5);
        chk("st_a", reg_a, 4);
        chk("st_pc", pc, 4);
        step_req = 1'b0;
        mode = 2'b10;
        tick(10);
        chk("rr_pc", pc, 14);
        chk("rr_h", halted, 0);
        tick(5);
        chk("rr2_pc", pc, 3);
        chk("rr2_a", reg_a, 3);
        tick();
        chk("rehalt", halted, 1);
        do_restart();
        chk("rsb_h", halted, 0);
        chk("rsb_pc", pc, 0);
        chk("rsb_a", reg_a, 0);
        tick();
        chk("rsb_run_pc", pc, 1);

        // ISA spot checks
        bp_en = 1'b0;
        load(4'd0, 4'b0111, 4'h9);  // MOV B,9
        load(4'd1, 4'b1001, 4'h0);  // OUT B
        load(4'd2, 4'b1110, 4'h5);  // JNC 5 (taken)
        load(4'd5, 4'b0010, 4'h0);  // IN A
        load(4'd6, 4'b1011, 4'h7);  // OUT 7
        load(4'd7, 4'b0001, 4'h0);  // MOV A,B
        load(4'd8, 4'b0000, 4'hF);  // ADD A,F
        load(4'd9, 4'b1110, 4'h0);  // JNC 0 (not taken)
        do_restart();
        in_port = 4'h6;
        mode = 2'b10;
        tick();
        chk("movb", reg_b, 9);
        tick();
        chk("outb", out_port, 9);
        tick();
        chk("jnc_t", pc, 5);
        tick();
        chk("ina", reg_a, 6);
        tick();
        chk("outim", out_port, 7);
        tick();
        chk("movab", reg_a, 9);
        tick();
        chk("add_a", reg_a, 8);
        chk("add_c", carry, 1);
        tick();
        chk("jnc_n_pc", pc, 10);
        chk("jnc_n_c", carry, 0);

        // async reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc, 0);
        chk("ar_a", reg_a, 0);
        chk("ar_b", reg_b, 0);
        chk("ar_out", out_port, 0);
        chk("ar_mem", {mem_op, mem_imm}, 0);
        #10;
        rst_n = 1'b1;
        mode = 2'b01; ld_addr = 4'd0;
        tick();
        chk("ar_mem0", {mem_op, mem_imm}, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
